// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: per-slot skid buffer state and entry count.
package cpu_types_pkg;

  typedef enum logic [1:0] {SLOT_EMPTY, SLOT_ONE, SLOT_FULL} skid_state_t;

  localparam int SKID_ENTRIES = 2;

endpackage

// File: rtl/skid_slot.sv
// One valid/ready slot with a main register and a one-deep skid register.
// in_ready depends only on the state register, so it is fully registered.
module skid_slot
  import cpu_types_pkg::*;
#(
  parameter int                WIDTH     = 32,
  parameter logic [WIDTH-1:0]  FLUSH_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_t      state_reg, state_next;
  logic [WIDTH-1:0] main_reg, main_next;
  logic [WIDTH-1:0] skid_reg, skid_next;
  logic             fire_in, fire_out;

  assign in_ready  = (state_reg != SLOT_FULL);
  assign out_valid = (state_reg != SLOT_EMPTY);
  assign out_data  = main_reg;
  assign fire_in   = in_valid & in_ready;
  assign fire_out  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= SLOT_EMPTY;
      main_reg  <= FLUSH_VAL;
      skid_reg  <= FLUSH_VAL;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (flush) begin
      state_next = SLOT_EMPTY;
      main_next  = FLUSH_VAL;
      skid_next  = FLUSH_VAL;
    end else begin
      case (state_reg)
        SLOT_EMPTY: begin
          if (fire_in) begin
            main_next  = in_data;
            state_next = SLOT_ONE;
          end
        end
        SLOT_ONE: begin
          if (fire_in && fire_out) begin
            main_next = in_data;
          end else if (fire_in) begin
            skid_next  = in_data;
            state_next = SLOT_FULL;
          end else if (fire_out) begin
            // main keeps its last value so out_data stays defined while idle
            state_next = SLOT_EMPTY;
          end
        end
        SLOT_FULL: begin
          if (fire_out) begin
            main_next  = skid_reg;
            state_next = SLOT_ONE;
          end
        end
        default: state_next = SLOT_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline register: DEPTH chained skid slots with flush and occupancy.
// Define PIPE_STAGE_SKID_STATS_EN to add saturating stall_cnt / flush_cnt outputs.
module pipe_stage_skid
  import cpu_types_pkg::*;
#(
  parameter int                WIDTH     = 32,
  parameter int                DEPTH     = 1,
  parameter logic [WIDTH-1:0]  FLUSH_VAL = '0
) (
  input  logic                                        CLK,
  input  logic                                        nRST,
  input  logic                                        flush,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [WIDTH-1:0]                            in_data,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [WIDTH-1:0]                            out_data,
`ifdef PIPE_STAGE_SKID_STATS_EN
  output logic [31:0]                                 stall_cnt,
  output logic [31:0]                                 flush_cnt,
`endif
  output logic [$clog2(SKID_ENTRIES*DEPTH+1)-1:0]     occupancy
);

  localparam int OCC_W = $clog2(SKID_ENTRIES*DEPTH+1);

  // Index k is the input side of slot k; index DEPTH is the block output.
  logic [DEPTH:0]   chain_valid;
  logic [DEPTH:0]   chain_ready;
  logic [WIDTH-1:0] chain_data [DEPTH+1];

  assign chain_valid[0]     = in_valid;
  assign chain_data[0]      = in_data;
  assign in_ready           = chain_ready[0];
  assign out_valid          = chain_valid[DEPTH];
  assign out_data           = chain_data[DEPTH];
  assign chain_ready[DEPTH] = out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi = gi + 1) begin : g_slot
      skid_slot #(
        .WIDTH     (WIDTH),
        .FLUSH_VAL (FLUSH_VAL)
      ) u_slot (
        .clk       (CLK),
        .rst_n     (nRST),
        .flush     (flush),
        .in_valid  (chain_valid[gi]),
        .in_ready  (chain_ready[gi]),
        .in_data   (chain_data[gi]),
        .out_valid (chain_valid[gi+1]),
        .out_ready (chain_ready[gi+1]),
        .out_data  (chain_data[gi+1])
      );
    end
  endgenerate

  // Internal slot-to-slot moves conserve the total, so only the ends matter.
  logic [OCC_W-1:0] occ_reg, occ_next;
  logic             top_fire_in, top_fire_out;

  assign top_fire_in  = in_valid & in_ready;
  assign top_fire_out = out_valid & out_ready;
  assign occupancy    = occ_reg;

  always_comb begin
    occ_next = occ_reg + OCC_W'(top_fire_in) - OCC_W'(top_fire_out);
    if (flush) begin
      occ_next = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      occ_reg <= '0;
    end else begin
      occ_reg <= occ_next;
    end
  end

`ifdef PIPE_STAGE_SKID_STATS_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
      if (flush && (flush_cnt_reg != 32'hFFFF_FFFF)) begin
        flush_cnt_reg <= flush_cnt_reg + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a FIFO queue is the reference for ordering and occupancy.
module tb_pipe_stage_skid;

  localparam int          WIDTH = 16;
  localparam int          DEPTH = 2;
  localparam logic [15:0] FV    = 16'h5A5A;
  localparam int          OCC_W = $clog2(2*DEPTH+1);

  logic             CLK = 1'b0;
  logic             nRST = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;
`ifdef PIPE_STAGE_SKID_STATS_EN
  logic [31:0]      stall_cnt;
  logic [31:0]      flush_cnt;
`endif

  pipe_stage_skid #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FLUSH_VAL(FV)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef PIPE_STAGE_SKID_STATS_EN
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
`endif
    .occupancy (occupancy)
  );

  always #5 CLK = ~CLK;

  int          n_total = 0;
  int          n_pass  = 0;
  int          n_out   = 0;
  bit          done    = 1'b0;
  logic [15:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One cycle of stimulus; the model queue is updated at the edge the DUT sees.
  task automatic step(input logic v, input logic [15:0] d, input logic r, input logic f,
                      output logic acc);
    logic fl;
    in_valid = v; in_data = d; out_ready = r; flush = f;
    @(negedge CLK);
    acc = in_valid && in_ready && !flush;
    fl  = flush;
    @(posedge CLK);
    if (fl) exp_q.delete();
    else if (acc) exp_q.push_back(d);
    #1;
  endtask

  // Monitor: pops expected payloads whenever the DUT completes an output transfer.
  initial begin
    logic        hold_prev = 1'b0;
    logic        flush_prev = 1'b0;
    logic [15:0] data_prev = '0;
    while (!done) begin
      @(negedge CLK);
      if (!nRST) begin
        hold_prev = 1'b0;
        continue;
      end
      check("occupancy", 32'(occupancy), 32'(exp_q.size()));
      if (occupancy == 0) check("in_ready_empty", 32'(in_ready), 32'd1);
      if (occupancy == OCC_W'(2*DEPTH)) check("in_ready_full", 32'(in_ready), 32'd0);
      if (hold_prev && !flush_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(data_prev));
      end
      if (out_valid && out_ready) begin
        n_out++;
        $display("out %0d data=%h", n_out, out_data);
        if (exp_q.size() == 0) check("out_unexpected", 32'd1, 32'd0);
        else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
      hold_prev  = out_valid && !out_ready;
      flush_prev = flush;
      data_prev  = out_data;
    end
  end

  initial begin
    logic        acc;
    int          cnt;
    logic        pend_v;
    logic [15:0] pend_d;
    logic        v, r, f;
    logic [15:0] d;

    // Reset held with the clock running
    repeat (3) @(posedge CLK);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_out_data", 32'(out_data), 32'(FV));
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // Streaming: first out 2 edges after first accept, then one per cycle
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 16'h10 + 16'(i), 1'b1, 1'b0, acc);
      check("stream_accept", 32'(acc), 32'd1);
      if (i == 0) check("stream_latency_valid", 32'(out_valid), 32'd0);
      else begin
        check("stream_occ", 32'(occupancy), 32'd2);
        check("stream_head", 32'(out_data), 32'h10 + 32'(i) - 32'd1);
      end
    end
    repeat (4) step(1'b0, 16'h0, 1'b1, 1'b0, acc);

    // Backpressure: fills to 2*DEPTH, next payload held until space frees
    cnt = 0;
    repeat (6) begin
      step(1'b1, 16'hA + 16'(cnt), 1'b0, 1'b0, acc);
      if (acc) cnt++;
    end
    check("bp_accepted", 32'(cnt), 32'(2*DEPTH));
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_occ", 32'(occupancy), 32'(2*DEPTH));
    for (int i = 0; i < 10 && cnt < 6; i++) begin
      step(1'b1, 16'hA + 16'(cnt), 1'b1, 1'b0, acc);
      if (acc) cnt++;
    end
    check("bp_all_accepted", 32'(cnt), 32'd6);
    repeat (8) step(1'b0, 16'h0, 1'b1, 1'b0, acc);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Flush with a same-cycle offer that must be discarded
    for (int i = 1; i <= 3; i++) step(1'b1, 16'(i), 1'b0, 1'b0, acc);
    check("fl_occ_before", 32'(occupancy), 32'd3);
    step(1'b1, 16'hDEAD, 1'b0, 1'b1, acc);
    check("fl_occ", 32'(occupancy), 32'd0);
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_out_data", 32'(out_data), 32'(FV));
    check("fl_in_ready", 32'(in_ready), 32'd1);
    repeat (4) step(1'b0, 16'h0, 1'b1, 1'b0, acc);

    // Asynchronous reset between edges
    step(1'b1, 16'h0111, 1'b0, 1'b0, acc);
    step(1'b1, 16'h0222, 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    check("ar_occ_before", 32'(occupancy), 32'd2);
    #1 nRST = 1'b0;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_occ", 32'(occupancy), 32'd0);
    check("ar_in_ready", 32'(in_ready), 32'd1);
    check("ar_out_data", 32'(out_data), 32'(FV));
    exp_q.delete();
    #1 nRST = 1'b1;
    @(posedge CLK);
    #1;
    step(1'b1, 16'h1, 1'b1, 1'b0, acc);
    step(1'b1, 16'h2, 1'b1, 1'b0, acc);
    repeat (4) step(1'b0, 16'h0, 1'b1, 1'b0, acc);
    check("ar_restream_done", 32'(n_out >= 2 && exp_q.size() == 0), 32'd1);

    // Stats: 5 stalled cycles then 2 flush edges, from a fresh reset
    #2 nRST = 1'b0;
    #2 nRST = 1'b1;
    exp_q.delete();
    @(posedge CLK);
    #1;
    step(1'b1, 16'h77, 1'b0, 1'b0, acc);
    step(1'b0, 16'h0, 1'b0, 1'b0, acc);
    repeat (5) step(1'b0, 16'h0, 1'b0, 1'b0, acc);
    step(1'b0, 16'h0, 1'b1, 1'b1, acc);
    step(1'b0, 16'h0, 1'b0, 1'b1, acc);
`ifdef PIPE_STAGE_SKID_STATS_EN
    check("stall_cnt", stall_cnt, 32'd5);
    check("flush_cnt", flush_cnt, 32'd2);
`endif

    // Randomised traffic, upstream holds its offer until accepted or flushed
    pend_v = 1'b0;
    pend_d = '0;
    for (int i = 0; i < 600; i++) begin
      if (pend_v) begin
        v = 1'b1;
        d = pend_d;
      end else begin
        v = ($urandom_range(0, 9) < 7);
        d = 16'($urandom);
      end
      r = ($urandom_range(0, 9) < 6);
      f = ($urandom_range(0, 39) == 0);
      step(v, d, r, f, acc);
      pend_v = v && !acc && !f;
      pend_d = d;
    end
    repeat (10) step(1'b0, 16'h0, 1'b1, 1'b0, acc);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    done = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
